// File: rtl/alu_operand_sequencer.sv
// ============================================================================
// Module   : alu_operand_sequencer
// Brief    : Collects A/B operand beats, drives an external ALU, registers result
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_operand_sequencer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   input  logic             in_chain,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic [7:0]       op_count
);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      EXEC   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_sel;
   logic [WIDTH-1:0] r_out;
   logic [7:0]       r_cnt;
   logic             w_in_acc;
   logic             w_out_acc;

   assign w_in_acc  = in_valid & in_ready;
   assign w_out_acc = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LOAD_A;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         LOAD_A: begin
            in_ready = 1'b1;
            if (w_in_acc) begin
               w_next = in_chain ? EXEC : LOAD_B;
            end
         end
         LOAD_B: begin
            in_ready = 1'b1;
            if (w_in_acc) begin
               w_next = EXEC;
            end
         end
         EXEC: begin
            w_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (w_out_acc) begin
               w_next = LOAD_A;
            end
         end
         default: begin
            w_next = LOAD_A;
         end
      endcase
   end

   // A chained first beat reuses the last result as A and skips the B beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_sel <= 2'b00;
      end else if (w_in_acc) begin
         if (r_state == LOAD_A) begin
            if (in_chain) begin
               r_a   <= r_out;
               r_b   <= in_data;
               r_sel <= in_op;
            end else begin
               r_a <= in_data;
            end
         end else begin
            r_b   <= in_data;
            r_sel <= in_op;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '0;
         r_cnt <= 8'd0;
      end else begin
         if (r_state == EXEC) begin
            r_out <= alu_out;
         end
         if (w_out_acc) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign alu_a    = r_a;
   assign alu_b    = r_b;
   assign alu_sel  = r_sel;
   assign out_data = r_out;
   assign out_zero = (r_out == '0);
   assign op_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
// ============================================================================
// Module   : tb_alu_operand_sequencer
// Brief    : Directed self-checking bench with a behavioural ALU attached
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_sequencer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_data;
   logic [1:0] in_op;
   logic       in_chain;
   logic [4:0] alu_a;
   logic [4:0] alu_b;
   logic [1:0] alu_sel;
   logic [4:0] alu_out;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_data;
   logic       out_zero;
   logic [7:0] op_count;

   int n_vec;
   int n_bad;

   alu_operand_sequencer #(.WIDTH(5)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_op     (in_op),
      .in_chain  (in_chain),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU
   always_comb begin
      alu_out = 5'd0;
      case (alu_sel)
         2'b00: alu_out = alu_a & alu_b;
         2'b01: alu_out = alu_a + alu_b;
         2'b10: alu_out = alu_a | alu_b;
         2'b11: alu_out = alu_a ^ alu_b;
         default: alu_out = 5'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [4:0] d, input logic [1:0] op, input logic ch);
      in_valid = 1'b1;
      in_data  = d;
      in_op    = op;
      in_chain = ch;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_chain = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
   endtask

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 5'd21;
      in_op     = 2'b11;
      in_chain  = 1'b0;
      out_ready = 1'b0;

      // Reset state, with a beat presented throughout reset
      cyc();
      cyc();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_zero", out_zero, 1);
      check("rst_op_count", op_count, 0);
      check("rst_alu_a", alu_a, 0);
      #3;
      in_valid = 1'b0;
      rst_n    = 1'b1;
      cyc();
      check("rst_no_capture", alu_a, 0);

      // Basic 12 + 7
      beat(5'd12, 2'b00, 1'b0);
      check("basic_a", alu_a, 12);
      beat(5'd7, 2'b01, 1'b0);
      check("basic_exec_valid", out_valid, 0);
      check("basic_exec_ready", in_ready, 0);
      cyc();
      check("basic_valid", out_valid, 1);
      check("basic_data", out_data, 19);
      check("basic_zero", out_zero, 0);
      handshake();
      check("basic_count", op_count, 1);
      check("basic_back_ready", in_ready, 1);
      check("basic_persist", out_data, 19);

      // Overflow 31 + 1
      beat(5'd31, 2'b00, 1'b0);
      beat(5'd1, 2'b01, 1'b0);
      cyc();
      check("ovf_data", out_data, 0);
      check("ovf_zero", out_zero, 1);
      handshake();

      // Chain: 12 AND 10 = 8, then 8 XOR 3 = 11
      beat(5'd12, 2'b00, 1'b0);
      beat(5'd10, 2'b00, 1'b0);
      cyc();
      check("and_data", out_data, 8);
      handshake();
      beat(5'd3, 2'b11, 1'b1);
      check("chain_alu_a", alu_a, 8);
      check("chain_alu_b", alu_b, 3);
      check("chain_sel", alu_sel, 3);
      check("chain_no_loadb", in_ready, 0);
      cyc();
      check("chain_valid", out_valid, 1);
      check("chain_data", out_data, 11);
      handshake();
      check("chain_count", op_count, 4);

      // Backpressure: 5 OR 10 = 15, held in DONE for 5 cycles with beats offered
      beat(5'd5, 2'b00, 1'b0);
      beat(5'd10, 2'b10, 1'b0);
      cyc();
      in_valid = 1'b1;
      in_data  = 5'd1;
      in_op    = 2'b01;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("bp_data", out_data, 15);
         check("bp_in_ready", in_ready, 0);
         check("bp_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      check("bp_a_held", alu_a, 5);
      check("bp_b_held", alu_b, 10);
      handshake();
      check("bp_count", op_count, 5);
      check("bp_load_a", in_ready, 1);

      // Stall between A and B; chain flag on the B beat is ignored
      beat(5'd9, 2'b00, 1'b0);
      in_data  = 5'd30;
      in_chain = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_ready", in_ready, 1);
         check("stall_a", alu_a, 9);
      end
      beat(5'd4, 2'b01, 1'b1);
      check("stall_b_a", alu_a, 9);
      cyc();
      check("stall_data", out_data, 13);
      handshake();
      check("stall_count", op_count, 6);

      // Reset while in EXEC
      beat(5'd3, 2'b00, 1'b0);
      beat(5'd2, 2'b01, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rexec_valid", out_valid, 0);
      check("rexec_ready", in_ready, 1);
      check("rexec_data", out_data, 0);
      check("rexec_zero", out_zero, 1);
      check("rexec_count", op_count, 0);
      check("rexec_a", alu_a, 0);
      #4;
      rst_n = 1'b1;
      cyc();

      // Chained first operation after reset uses A = 0
      beat(5'd6, 2'b01, 1'b1);
      check("rchain_a", alu_a, 0);
      cyc();
      check("rchain_data", out_data, 6);

      // Reset while in DONE
      #2;
      rst_n = 1'b0;
      #1;
      check("rdone_valid", out_valid, 0);
      check("rdone_data", out_data, 0);
      check("rdone_sel", alu_sel, 0);
      #4;
      rst_n = 1'b1;
      cyc();

      // Full sequence after reset: 20 XOR 5 = 17
      beat(5'd20, 2'b00, 1'b0);
      beat(5'd5, 2'b11, 1'b0);
      cyc();
      check("post_rst_data", out_data, 17);
      handshake();
      check("post_rst_count", op_count, 1);

      // op_count wrap: run to 256 handshakes
      for (int i = 1; i < 256; i++) begin
         beat(5'(i), 2'b00, 1'b0);
         beat(5'd1, 2'b10, 1'b0);
         cyc();
         if (i == 254) begin
            check("wrap_or_data", out_data, 31);
         end
         handshake();
         if (i == 254) begin
            check("wrap_255", op_count, 255);
         end
      end
      check("wrap_0", op_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 Parameter: WIDTH, 5, operand and result width in bits; only 5 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_ready  output  1  sequencer can accept a beat.
REQ-006 in_data  input  WIDTH  operand carried by the beat.
REQ-007 in_op  input  2  operation code, sampled on the B beat or the chain beat: 00 AND, 01 ADD, 10 OR, 11 XOR.
REQ-008 in_chain  input  1  on the first beat, use the previous result as operand A.
REQ-009 alu_a  output  WIDTH  operand A to the downstream ALU (ALU input InA).
REQ-010 alu_b  output  WIDTH  operand B to the ALU (ALU input InB).
REQ-011 alu_sel  output  2  operation select to the ALU (ALU input select).
REQ-012 alu_out  input  WIDTH  combinational ALU result (ALU output Out).
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_data  output  WIDTH  registered result.
REQ-016 out_zero  output  1  out_data equals 0.
REQ-017 op_count  output  8  number of completed result handshakes.

Function
REQ-018 FSM states SHALL be LOAD_A, LOAD_B, EXEC and DONE; there SHALL be no other reachable state.
REQ-019 A beat SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
- in_ready SHALL be 1 in LOAD_A and LOAD_B.
- in_ready SHALL be 0 in EXEC and DONE.
REQ-020 LOAD_A, accepted beat with in_chain=0: capture A := in_data, then go to LOAD_B.
REQ-021 LOAD_A, accepted beat with in_chain=1:
- capture A := out_data register, B := in_data, sel := in_op;
- go to EXEC, skipping LOAD_B.
REQ-022 LOAD_B, accepted beat: capture B := in_data, sel := in_op, then go to EXEC; in_chain SHALL be ignored in LOAD_B.
REQ-023 alu_a, alu_b and alu_sel SHALL be driven directly from the A, B and sel registers, with no combinational path from in_data.
REQ-024 EXEC SHALL last exactly one cycle: out_data := alu_out, then go to DONE.
- Latency is 1 cycle from the accepting edge of the last beat to EXEC, and 2 cycles to out_valid=1.
REQ-025 out_valid SHALL be 1 exactly while in DONE.
- out_data SHALL hold stable in DONE until out_valid and out_ready are both 1 on an edge.
- On that edge the FSM returns to LOAD_A.
REQ-026 op_count SHALL increment by 1 on each out handshake and wrap from 255 to 0.
REQ-027 out_zero SHALL be combinational from out_data.
REQ-028 Absent a handshake, each state SHALL hold, and the A, B and sel registers SHALL hold their values.
REQ-029 out_data SHALL persist after the handshake and serves as the chain source for the next operation.
REQ-030 Arithmetic SHALL be entirely inside the ALU; ADD overflow truncates to WIDTH bits and is not reported.

Reset
REQ-031 When rst_n=0, the block SHALL immediately go to LOAD_A, regardless of clock and of the current state, including mid-operation.
REQ-032 During reset the block SHALL clear A, B, sel, out_data and op_count to 0, which gives out_valid=0, in_ready=1 and out_zero=1.
REQ-033 A beat presented during reset, or in the same cycle rst_n deasserts, SHALL NOT be captured; the first accepted beat is on the first rising edge with rst_n=1 already stable.
REQ-034 A chained first operation after reset SHALL use A=0.

Verification
REQ-035 Basic: A=5'd12, B=5'd7, op=01 -> out_valid 2 cycles after the B beat, out_data=5'd19, out_zero=0, op_count=1.
REQ-036 Overflow and wrap:
- A=31, B=1, op=01 -> out_data=0, out_zero=1.
- After 256 handshakes, op_count=0.
REQ-037 Chain: compute 12 AND 10 = 8, then send a chain beat with in_data=3, op=11 -> alu_a=8, out_data=5'd11, with no LOAD_B beat consumed.
REQ-038 Backpressure:
- Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, no beat accepted.
- Release out_ready -> return to LOAD_A, op_count increments once.
REQ-039 Reset in EXEC or DONE: assert rst_n=0 -> all outputs at reset values immediately; the next full A,B sequence completes normally.
REQ-040 Stall: drop in_valid between the A and B beats for 3 cycles -> remain in LOAD_B, A register unchanged; the result is correct once B arrives.
